// File: rtl/div_iter_pkg.sv
// div_iter_pkg: shared definitions for the iterative divider.
//   - div_state_e : FSM state encoding (DivIdle, DivBusy, DivByZero, DivDone)
//   - DivStart/DivStop, DivResultReady/DivResultNotReady : handshake levels
// Optional feature macro: DIV_ANNUL_EN (undefined by default; define it on the
// tool command line to add the annul_i abort port to div_iter).
package div_iter_pkg;

  typedef enum logic [1:0] {
    DivIdle   = 2'd0,
    DivBusy   = 2'd1,
    DivByZero = 2'd2,
    DivDone   = 2'd3
  } div_state_e;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

endpackage

// File: rtl/div_iter_step.sv
// div_iter_step: one combinational radix-2 restoring step.
//   i_rem      [WIDTH-1:0]  partial remainder before the step (always < divisor)
//   i_dvd_msb               dividend bit shifted into the remainder
//   i_divisor  [WIDTH-1:0]  divisor magnitude
//   o_rem      [WIDTH-1:0]  partial remainder after the step
//   o_qbit                  quotient bit produced by this step
module div_iter_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_dvd_msb,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_qbit
);

  // The shifted remainder and trial difference are WIDTH+1 bits so the borrow
  // is the explicit top bit: shift < 2*divisor keeps the difference in range.
  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;

  assign w_shift = {i_rem, i_dvd_msb};
  assign w_diff  = w_shift - {1'b0, i_divisor};
  assign o_qbit  = ~w_diff[WIDTH];
  assign o_rem   = o_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];

endmodule

// File: rtl/div_iter.sv
// div_iter: iterative radix-2 restoring divider (div / divu) for the EX stage.
//   clk           rising-edge clock
//   rst           asynchronous active-low reset
//   start_i       request, held until ready_o
//   signed_i      1 = signed div, 0 = divu (sampled with start_i)
//   annul_i       abort in-flight division (only with DIV_ANNUL_EN)
//   opdata1_i     dividend, opdata2_i divisor (sampled with start_i)
//   result_o      {remainder, quotient}
//   ready_o       result valid
//   busy_o        high in every state except IDLE
//   div_by_zero_o current result came from a zero divisor
// Optional feature macro: DIV_ANNUL_EN.
module div_iter
  import div_iter_pkg::*;
#(
  parameter  int unsigned WIDTH = 32,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_i,
`ifdef DIV_ANNUL_EN
  input  logic               annul_i,
`endif
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o,
  output logic               div_by_zero_o
);

  div_state_e         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_dvd;   // dividend magnitude; quotient bits shift in at the bottom
  logic [WIDTH-1:0]   r_dsr;
  logic [WIDTH-1:0]   r_rem;
  logic               r_qneg;
  logic               r_rneg;
  logic [2*WIDTH-1:0] r_result;
  logic               r_ready;
  logic               r_dbz;

  logic               w_annul;
  logic               w_sign1;
  logic               w_sign2;
  logic [WIDTH-1:0]   w_mag1;
  logic [WIDTH-1:0]   w_mag2;
  logic [WIDTH-1:0]   w_rem_next;
  logic               w_qbit;
  logic [WIDTH-1:0]   w_quot_fix;
  logic [WIDTH-1:0]   w_rem_fix;

`ifdef DIV_ANNUL_EN
  assign w_annul = annul_i;
`else
  assign w_annul = 1'b0;
`endif

  assign w_sign1 = signed_i & opdata1_i[WIDTH-1];
  assign w_sign2 = signed_i & opdata2_i[WIDTH-1];
  assign w_mag1  = w_sign1 ? ('0 - opdata1_i) : opdata1_i;
  assign w_mag2  = w_sign2 ? ('0 - opdata2_i) : opdata2_i;

  assign w_quot_fix = r_qneg ? ('0 - r_dvd) : r_dvd;
  assign w_rem_fix  = r_rneg ? ('0 - r_rem) : r_rem;

  div_iter_step #(.WIDTH(WIDTH)) u_step (
    .i_rem     (r_rem),
    .i_dvd_msb (r_dvd[WIDTH-1]),
    .i_divisor (r_dsr),
    .o_rem     (w_rem_next),
    .o_qbit    (w_qbit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= DivIdle;
      r_cnt    <= '0;
      r_dvd    <= '0;
      r_dsr    <= '0;
      r_rem    <= '0;
      r_qneg   <= 1'b0;
      r_rneg   <= 1'b0;
      r_result <= '0;
      r_ready  <= DivResultNotReady;
      r_dbz    <= 1'b0;
    end else begin
      case (r_state)
        DivIdle: begin
          if (start_i == DivStart && !w_annul) begin
            r_cnt <= '0;
            if (opdata2_i == '0) begin
              r_state <= DivByZero;
            end else begin
              r_dvd   <= w_mag1;
              r_dsr   <= w_mag2;
              r_qneg  <= w_sign1 ^ w_sign2;
              r_rneg  <= w_sign1;
              r_rem   <= '0;
              r_state <= DivBusy;
            end
          end
        end
        DivBusy: begin
          if (w_annul) begin
            r_state <= DivIdle;
          end else if (r_cnt == CNT_W'(WIDTH)) begin
            // All WIDTH steps done on previous edges; this edge only applies
            // the sign fix-up and publishes the result.
            r_result <= {w_rem_fix, w_quot_fix};
            r_ready  <= DivResultReady;
            r_dbz    <= 1'b0;
            r_state  <= DivDone;
          end else begin
            r_rem <= w_rem_next;
            r_dvd <= {r_dvd[WIDTH-2:0], w_qbit};
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        DivByZero: begin
          // Two cycles here so a zero divisor reports ready after E2.
          if (w_annul) begin
            r_state <= DivIdle;
          end else if (r_cnt == CNT_W'(1)) begin
            r_result <= '0;
            r_ready  <= DivResultReady;
            r_dbz    <= 1'b1;
            r_state  <= DivDone;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        DivDone: begin
          if (start_i == DivStop) begin
            r_ready <= DivResultNotReady;
            r_dbz   <= 1'b0;
            r_state <= DivIdle;
          end
        end
        default: r_state <= DivIdle;
      endcase
    end
  end

  assign result_o      = r_result;
  assign ready_o       = r_ready;
  assign div_by_zero_o = r_dbz;
  assign busy_o        = (r_state != DivIdle);

endmodule

// File: tb/tb_div_iter.sv
module tb_div_iter;

  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start = 1'b0;
  logic          sgn = 1'b0;
`ifdef DIV_ANNUL_EN
  logic          annul = 1'b0;
`endif
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [2*W-1:0] result;
  logic          ready;
  logic          busy;
  logic          dbz;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  div_iter #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start),
    .signed_i      (sgn),
`ifdef DIV_ANNUL_EN
    .annul_i       (annul),
`endif
    .opdata1_i     (a),
    .opdata2_i     (b),
    .result_o      (result),
    .ready_o       (ready),
    .busy_o        (busy),
    .div_by_zero_o (dbz)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference: truncating division on 64-bit integers; the remainder takes the
  // dividend's sign, and the results are truncated to 32 bits.
  function automatic logic [63:0] ref_div(input logic [31:0] x, input logic [31:0] y,
                                          input logic s);
    longint sx, sy, q, r;
    if (y == 0) return 64'd0;
    if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
    end else begin
      sx = longint'({32'd0, x});
      sy = longint'({32'd0, y});
    end
    q = sx / sy;
    r = sx % sy;
    return {32'(r), 32'(q)};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic do_div(input logic [31:0] x, input logic [31:0] y, input logic s,
                        input int hold, input string tag);
    logic [63:0] exp;
    int          lat;
    logic        busy_ok;
    exp = ref_div(x, y, s);
    @(posedge clk); #1;
    start = 1'b1; a = x; b = y; sgn = s;
    @(posedge clk); #1;          // after E0
    a = $urandom; b = $urandom; sgn = ~s;
    lat = 0;
    busy_ok = 1'b1;
    while (!ready && lat < 100) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 64'(lat), (y == 0) ? 64'd2 : 64'(W + 1));
    check({tag, " busy"}, {63'd0, busy_ok & busy}, 64'd1);
    check({tag, " result"}, result, exp);
    check({tag, " dbz"}, {63'd0, dbz}, {63'd0, (y == 0)});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, " hold ready"}, {62'd0, ready, busy}, 64'd3);
      check({tag, " hold result"}, result, exp);
    end
    start = 1'b0;
    @(posedge clk); #1;
    check({tag, " drop flags"}, {61'd0, ready, dbz, busy}, 64'd0);
    check({tag, " drop result"}, result, exp);
  endtask

  initial begin
    logic [31:0] x, y;
    logic        s;
    int          seen;

    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("reset outputs", {61'd0, ready, busy, dbz}, 64'd0);
    check("reset result", result, 64'd0);
    #10 rst = 1'b1;

    do_div(32'd100, 32'd7, 1'b0, 0, "divu 100/7");
    check("divu 100/7 literal", result, {32'h0000_0002, 32'h0000_000E});
    do_div(32'hFFFF_FFF9, 32'd2, 1'b1, 0, "div -7/2");
    check("div -7/2 literal", result, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    do_div(32'd7, 32'hFFFF_FFFE, 1'b1, 0, "div 7/-2");
    check("div 7/-2 literal", result, {32'h0000_0001, 32'hFFFF_FFFD});
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, "div MN/-1");
    check("div MN/-1 literal", result, {32'h0, 32'h8000_0000});
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, "divu MN/FF");
    check("divu MN/FF literal", result, {32'h8000_0000, 32'h0});
    do_div(32'd55, 32'd0, 1'b0, 0, "divu by zero");
    do_div(32'hFFFF_FFF0, 32'd0, 1'b1, 0, "div by zero");

    do_div(32'd1000, 32'd13, 1'b0, 5, "hold");
    do_div(32'd9, 32'd3, 1'b0, 0, "after hold 9/3");
    check("9/3 literal", result, {32'd0, 32'd3});

`ifdef DIV_ANNUL_EN
    @(posedge clk); #1;
    start = 1'b1; a = 32'd1000; b = 32'd3; sgn = 1'b0;
    @(posedge clk); #1;
    repeat (9) begin @(posedge clk); #1; end
    annul = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    annul = 1'b0;
    check("annul busy", {63'd0, busy}, 64'd0);
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (ready) seen++; end
    check("annul no ready", 64'(seen), 64'd0);
    do_div(32'd1000, 32'd3, 1'b0, 0, "after annul");
`endif

    // Reset in the middle of a division; previous result is nonzero.
    @(posedge clk); #1;
    start = 1'b1; a = 32'd12345; b = 32'd67; sgn = 1'b0;
    @(posedge clk); #1;
    repeat (20) begin @(posedge clk); #1; end
    #2 rst = 1'b0;
    #1;
    check("midreset flags", {61'd0, ready, busy, dbz}, 64'd0);
    check("midreset result", result, 64'd0);
    start = 1'b0;
    #1 rst = 1'b1;
    do_div(32'd12345, 32'd67, 1'b0, 0, "after reset");

    for (int k = 0; k < 40; k++) begin
      x = pick();
      y = pick();
      s = 1'($urandom_range(0, 1));
      do_div(x, y, s, int'($urandom_range(0, 2)), $sformatf("rand%0d", k));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
